ecc_alu_seq: RTL and testbench
==============================

# ecc_alu_seq

Command sequencer directly upstream of the ECC ALU wrapper (FA/MUL/INV/SWAP engine).
- Holds an 8×256-bit operand register file.
- Accepts one register-to-register command at a time over a valid/ready handshake, issues it to the ALU as a single `en` pulse, waits for ALU `vld`, then writes the result back.
- Detects illegal opcodes and hung operations; never issues a second operation while one is in flight.

## Interface
Parameters:
- `WID`, 256, operand width
- `NREG`, 8, register-file depth (address width 3)
- `TMO_CYC`, 65535, max cycles waiting for ALU `vld` before abort (16-bit counter)

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock
- `rst` in 1: asynchronous active-low reset
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: command accepted when both high
- `cmd_op` in 4: ALU opcode. [1:0] 00 FA, 01 MUL, 10 INV, 11 illegal; [2] X255/P256; [3] N/P
- `cmd_swap` in 1: issue conditional swap instead of `cmd_op`
- `cmd_swapvl` in 1: swap bit
- `cmd_cin` in 1: carry-in for FA
- `cmd_dst`, `cmd_srca`, `cmd_srcb` in 3 each: register addresses
- `wr_en` in 1, `wr_addr` in 3, `wr_data` in WID: host register load
- `rd_addr` in 3, `rd_data` out WID: combinational register readout
- `busy` out 1: command in flight
- `done` out 1: one-cycle pulse per completed command
- `err` out 1: sticky error flag
- `err_clr` in 1: clears `err`
- `alu_a`, `alu_b` out WID; `alu_c`, `alu_en`, `alu_swapop`, `alu_swapvl` out 1; `alu_opcode` out 4: ALU drive
- `alu_r`, `alu_rswap` in WID; `alu_vld` in 1; `alu_status` in 2: ALU results

## Operation
- States: IDLE, ISSUE, WAIT, WB.
- **IDLE**
  - `cmd_ready` = 1.
  - On handshake, latch all `cmd_*` fields.
  - Legal opcode, or `cmd_swap` = 1: go to ISSUE.
  - `cmd_op[1:0]` = 11 with `cmd_swap` = 0: set `err`, pulse `done` next cycle, return to IDLE without issuing. This is required because the ALU never returns `vld` for that code.
- **ISSUE**
  - Drive `alu_a` = reg[srca], `alu_b` = reg[srcb], plus opcode/carry/swap fields.
  - Assert `alu_en` for exactly one cycle, and only when `alu_status` = 00; otherwise hold in ISSUE.
  - After the pulse, go to WAIT and clear the timeout counter.
- **WAIT**
  - Keep all `alu_*` outputs stable.
  - On `alu_vld`, capture `alu_r`/`alu_rswap` and go to WB.
  - If the counter reaches `TMO_CYC` with no `vld`: set `err`, return to IDLE, no writeback.
- **WB**
  - Non-swap: reg[dst] ← `alu_r`.
  - Swap: reg[srca] ← `alu_r`, reg[srcb] ← `alu_rswap`; if srca = srcb, only `alu_r` is written.
  - Pulse `done`, go to IDLE.
- **Host writes**
  - `wr_en` is honoured only in IDLE; it is ignored otherwise.
  - A host write in the same cycle as a command handshake is visible to that command's operand read.
- **Errors**
  - `err` is set by an illegal opcode or a timeout.
  - Cleared by `err_clr`; set wins over a simultaneous clear.
- **Reset**
  - State IDLE; all registers 0.
  - `alu_en`, `busy`, `done`, `err` = 0; `alu_*` data outputs 0.
  - `cmd_ready` = 1 after reset deasserts.
  - Reset mid-operation abandons the command without writeback.

## Timing
- Handshake at edge 0 → `alu_en` high during cycle 1 (ALU idle) → `alu_vld` at cycle 1+L → register written and `done` high in cycle 2+L → `cmd_ready` high in cycle 3+L.
- `busy` = (state ≠ IDLE).
- `alu_vld` seen outside WAIT is ignored.
- Back-to-back commands: minimum issue spacing is L+3 cycles.
- `rd_data` reflects writes from the following cycle.

## Structure
- Shared package `ecc_pkg` holds:
  - opcode encodings (FA/MUL/INV, bit 2 = X255, bit 3 = N)
  - state encoding
  - `WID` / `NREG` defaults
- One natural sub-module: `ecc_regfile`, 8×WID with async read, one host/ALU write port, and a second write port for the swap `rswap` result.

## Test plan
Bench uses an ALU stub that returns a+b+c with `vld` L = 5 cycles after `en`.
- Load r1 = 3, r2 = 4; FA with cin = 1, dst = r0 → `alu_en` in cycle 1, `done` in cycle 7, r0 = 8, `err` = 0.
- Swap: r1 = 5, r2 = 9, swapvl = 1, stub exchanges → r1 = 9, r2 = 5. With srca = srcb = r3, only r3 is written.
- `cmd_op` = 0011 → no `alu_en`, `err` = 1, `done` pulse, registers unchanged; `err_clr` → `err` = 0.
- Stub never asserts `vld` → abort after 65535 cycles, `err` = 1, dst unchanged, `cmd_ready` = 1 next cycle.
- `alu_status` held at 01 for 10 cycles at issue → `alu_en` delayed until status = 00, still a single pulse.
- Reset asserted during WAIT → all outputs 0 immediately; no writeback; a command after release completes normally.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared encodings for the ECC ALU command path: opcodes, sequencer states, size defaults.
// Pure declarations; no latency and no flow control.
package ecc_pkg;

    localparam int WID_DEF  = 256;
    localparam int NREG_DEF = 8;
    localparam int AW       = 3;
    localparam int TMO_DEF  = 65535;

    // Low two opcode bits select the engine; bit 2 picks X255 over P256, bit 3 picks N over P.
    typedef enum logic [1:0] {
        OP_FA  = 2'b00,
        OP_MUL = 2'b01,
        OP_INV = 2'b10,
        OP_ILL = 2'b11
    } op_base_e;

    localparam int OP_BIT_X255 = 2;
    localparam int OP_BIT_N    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_WB    = 2'b11
    } state_e;

    function automatic logic op_legal(input logic [3:0] op, input logic swap);
        return swap || (op_base_e'(op[1:0]) != OP_ILL);
    endfunction

endpackage

// File: rtl/ecc_regfile.sv
// Operand register file: NREG x WID, three async read ports, two write ports (port a wins on clash).
// Writes land at the clock edge and are readable the following cycle; never stalls.
module ecc_regfile
    import ecc_pkg::*;
#(
    parameter int WID  = WID_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we_a,
    input  logic [AW-1:0]  wa_a,
    input  logic [WID-1:0] wd_a,
    input  logic           we_b,
    input  logic [AW-1:0]  wa_b,
    input  logic [WID-1:0] wd_b,
    input  logic [AW-1:0]  ra_0,
    input  logic [AW-1:0]  ra_1,
    input  logic [AW-1:0]  ra_2,
    output logic [WID-1:0] rd_0,
    output logic [WID-1:0] rd_1,
    output logic [WID-1:0] rd_2
);

    logic [WID-1:0] mem_q [NREG];
    logic [WID-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we_b) mem_d[wa_b] = wd_b;
        if (we_a) mem_d[wa_a] = wd_a;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_0 = mem_q[ra_0];
    assign rd_1 = mem_q[ra_1];
    assign rd_2 = mem_q[ra_2];

endmodule

// File: rtl/ecc_alu_seq.sv
// Single-outstanding command sequencer for the ECC ALU: issue, wait for vld, write back; L+3 cycles/command.
// cmd_ready only in IDLE; issue stalls while alu_status != 0; a missing vld aborts after TMO_CYC cycles.
module ecc_alu_seq
    import ecc_pkg::*;
#(
    parameter int WID     = WID_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int TMO_CYC = TMO_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [3:0]     cmd_op,
    input  logic           cmd_swap,
    input  logic           cmd_swapvl,
    input  logic           cmd_cin,
    input  logic [AW-1:0]  cmd_dst,
    input  logic [AW-1:0]  cmd_srca,
    input  logic [AW-1:0]  cmd_srcb,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [WID-1:0] wr_data,
    input  logic [AW-1:0]  rd_addr,
    output logic [WID-1:0] rd_data,
    output logic           busy,
    output logic           done,
    output logic           err,
    input  logic           err_clr,
    output logic [WID-1:0] alu_a,
    output logic [WID-1:0] alu_b,
    output logic           alu_c,
    output logic           alu_en,
    output logic           alu_swapop,
    output logic           alu_swapvl,
    output logic [3:0]     alu_opcode,
    input  logic [WID-1:0] alu_r,
    input  logic [WID-1:0] alu_rswap,
    input  logic           alu_vld,
    input  logic [1:0]     alu_status
);

    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

    state_e         state_q, state_d;
    logic [3:0]     op_q, op_d;
    logic           swap_q, swap_d;
    logic           swapvl_q, swapvl_d;
    logic           cin_q, cin_d;
    logic [AW-1:0]  dst_q, dst_d;
    logic [AW-1:0]  srca_q, srca_d;
    logic [AW-1:0]  srcb_q, srcb_d;
    logic [WID-1:0] a_q, a_d;
    logic [WID-1:0] b_q, b_d;
    logic [WID-1:0] r_q, r_d;
    logic [WID-1:0] rswap_q, rswap_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           err_set;

    logic           rf_we_a, rf_we_b;
    logic [AW-1:0]  rf_wa_a, rf_wa_b;
    logic [WID-1:0] rf_wd_a, rf_wd_b;
    logic [WID-1:0] rf_srca, rf_srcb;
    logic [WID-1:0] fwd_a, fwd_b;

    ecc_regfile #(.WID(WID), .NREG(NREG)) u_regfile (
        .clk  (clk),
        .rst  (rst),
        .we_a (rf_we_a),
        .wa_a (rf_wa_a),
        .wd_a (rf_wd_a),
        .we_b (rf_we_b),
        .wa_b (rf_wa_b),
        .wd_b (rf_wd_b),
        .ra_0 (rd_addr),
        .ra_1 (cmd_srca),
        .ra_2 (cmd_srcb),
        .rd_0 (rd_data),
        .rd_1 (rf_srca),
        .rd_2 (rf_srcb)
    );

    // A host write landing on the same edge as the handshake must feed the operand latch.
    assign fwd_a = (wr_en && wr_addr == cmd_srca) ? wr_data : rf_srca;
    assign fwd_b = (wr_en && wr_addr == cmd_srcb) ? wr_data : rf_srcb;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        swap_d   = swap_q;
        swapvl_d = swapvl_q;
        cin_d    = cin_q;
        dst_d    = dst_q;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        rswap_d  = rswap_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_set  = 1'b0;
        rf_we_a  = 1'b0;
        rf_wa_a  = wr_addr;
        rf_wd_a  = wr_data;
        rf_we_b  = 1'b0;
        rf_wa_b  = srcb_q;
        rf_wd_b  = rswap_q;

        unique case (state_q)
            ST_IDLE: begin
                rf_we_a = wr_en;
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    swap_d   = cmd_swap;
                    swapvl_d = cmd_swapvl;
                    cin_d    = cmd_cin;
                    dst_d    = cmd_dst;
                    srca_d   = cmd_srca;
                    srcb_d   = cmd_srcb;
                    a_d      = fwd_a;
                    b_d      = fwd_b;
                    if (op_legal(cmd_op, cmd_swap)) begin
                        state_d = ST_ISSUE;
                    end else begin
                        // The ALU never answers this code, so retire it here.
                        err_set = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (alu_status == 2'b00) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (alu_vld) begin
                    r_d     = alu_r;
                    rswap_d = alu_rswap;
                    done_d  = 1'b1;
                    state_d = ST_WB;
                end else if (cnt_q == TMO_LAST) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WB: begin
                rf_we_a = 1'b1;
                rf_wa_a = swap_q ? srca_q : dst_q;
                rf_wd_a = r_q;
                rf_we_b = swap_q && (srca_q != srcb_q);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        err_d = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            swap_q   <= 1'b0;
            swapvl_q <= 1'b0;
            cin_q    <= 1'b0;
            dst_q    <= '0;
            srca_q   <= '0;
            srcb_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            rswap_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            swap_q   <= swap_d;
            swapvl_q <= swapvl_d;
            cin_q    <= cin_d;
            dst_q    <= dst_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            rswap_q  <= rswap_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    // Gated by live status so the single pulse only goes out when the ALU can take it.
    assign alu_en     = (state_q == ST_ISSUE) && (alu_status == 2'b00);
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_c      = cin_q;
    assign alu_swapop = swap_q;
    assign alu_swapvl = swapvl_q;
    assign alu_opcode = op_q;

endmodule

// File: tb/tb_ecc_alu_seq.sv
// Directed bench for ecc_alu_seq with an ALU stub (a+b+c, or exchange on swap) answering 5 cycles after en.
module tb_ecc_alu_seq;
    import ecc_pkg::*;

    localparam int W = 256;
    localparam int L = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [3:0]     cmd_op = '0;
    logic           cmd_swap = 1'b0;
    logic           cmd_swapvl = 1'b0;
    logic           cmd_cin = 1'b0;
    logic [2:0]     cmd_dst = '0;
    logic [2:0]     cmd_srca = '0;
    logic [2:0]     cmd_srcb = '0;
    logic           wr_en = 1'b0;
    logic [2:0]     wr_addr = '0;
    logic [W-1:0]   wr_data = '0;
    logic [2:0]     rd_addr = '0;
    logic [W-1:0]   rd_data;
    logic           busy, done, err;
    logic           err_clr = 1'b0;
    logic [W-1:0]   alu_a, alu_b;
    logic           alu_c, alu_en, alu_swapop, alu_swapvl;
    logic [3:0]     alu_opcode;
    logic [W-1:0]   alu_r = '0;
    logic [W-1:0]   alu_rswap = '0;
    logic           alu_vld = 1'b0;
    logic [1:0]     alu_status = 2'b00;

    int checks = 0;
    int failures = 0;

    ecc_alu_seq dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_swap   (cmd_swap),
        .cmd_swapvl (cmd_swapvl),
        .cmd_cin    (cmd_cin),
        .cmd_dst    (cmd_dst),
        .cmd_srca   (cmd_srca),
        .cmd_srcb   (cmd_srcb),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_clr    (err_clr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_en     (alu_en),
        .alu_swapop (alu_swapop),
        .alu_swapvl (alu_swapvl),
        .alu_opcode (alu_opcode),
        .alu_r      (alu_r),
        .alu_rswap  (alu_rswap),
        .alu_vld    (alu_vld),
        .alu_status (alu_status)
    );

    always #5 clk = ~clk;

    // ALU stub; stub_xor perturbs rswap so a stray second write port use becomes visible.
    int           stub_k = 0;
    bit           stub_pend = 0;
    bit           stub_hang = 0;
    logic [W-1:0] stub_a = '0, stub_b = '0, stub_xor = '0;
    logic         stub_c = 0, stub_swap = 0, stub_swapvl = 0;
    logic [3:0]   stub_op = '0;

    always @(negedge clk) begin
        alu_vld = 1'b0;
        if (stub_pend) begin
            stub_k++;
            if (stub_k == L) begin
                stub_pend = 0;
                alu_vld   = !stub_hang;
                if (stub_swap) begin
                    alu_r     = stub_swapvl ? stub_b : stub_a;
                    alu_rswap = (stub_swapvl ? stub_a : stub_b) ^ stub_xor;
                end else begin
                    alu_r     = stub_a + stub_b + W'(stub_c);
                    alu_rswap = '0;
                end
            end
        end
        if (alu_en) begin
            stub_pend   = 1;
            stub_k      = 0;
            stub_a      = alu_a;
            stub_b      = alu_b;
            stub_c      = alu_c;
            stub_swap   = alu_swapop;
            stub_swapvl = alu_swapvl;
            stub_op     = alu_opcode;
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rdreg(input logic [2:0] a, output logic [W-1:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic send(input logic [3:0] op, input logic sw, input logic swv, input logic cin,
                        input logic [2:0] dst, input logic [2:0] sa, input logic [2:0] sb);
        cmd_op = op; cmd_swap = sw; cmd_swapvl = swv; cmd_cin = cin;
        cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the handshake edge.
    task automatic watch(input int hold, input int bound,
                         output int en_cyc, output int en_cnt, output int done_cyc, output int end_cyc);
        en_cyc = -1; en_cnt = 0; done_cyc = -1; end_cyc = -1;
        for (int i = 1; i <= bound; i++) begin
            if (i > hold && alu_status != 2'b00) begin
                alu_status = 2'b00;
                #1;
            end
            if (alu_en) begin
                en_cnt++;
                if (en_cyc < 0) en_cyc = i;
            end
            if (done) begin
                done_cyc = i;
                tick();
                end_cyc = i + 1;
                break;
            end
            if (!busy) begin
                end_cyc = i;
                break;
            end
            tick();
        end
    endtask

    int           en_cyc, en_cnt, done_cyc, end_cyc;
    logic [W-1:0] v;
    bit           done_seen;
    logic [3:0]   op_fa_x255, op_mul_n;

    initial begin
        op_fa_x255 = 4'(OP_FA) | 4'(1 << OP_BIT_X255);
        op_mul_n   = 4'(OP_MUL) | 4'(1 << OP_BIT_N);

        // Reset state
        #2;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_err", W'(err), W'(0));
        chk("rst_alu_en", W'(alu_en), W'(0));
        chk("rst_alu_a", alu_a, W'(0));
        tick();
        rst = 1'b1;
        tick();
        chk("rst_ready", W'(cmd_ready), W'(1));
        rdreg(3'd5, v); chk("rst_r5", v, W'(0));

        // FA: r0 = 3 + 4 + 1
        wr(3'd1, W'(3));
        wr(3'd2, W'(4));
        send(op_fa_x255, 0, 0, 1, 3'd0, 3'd1, 3'd2);
        watch(0, 40, en_cyc, en_cnt, done_cyc, end_cyc);
        chk("fa_en_cyc", W'(en_cyc), W'(1));
        chk("fa_en_cnt", W'(en_cnt), W'(1));
        chk("fa_done_cyc", W'(done_cyc), W'(7));
        chk("fa_ready_cyc", W'(end_cyc), W'(8));
        chk("fa_ready", W'(cmd_ready), W'(1));
        chk("fa_stub_a", stub_a, W'(3));
        chk("fa_stub_b", stub_b, W'(4));
        chk("fa_opcode", W'(stub_op), W'(4'b0100));
        rdreg(3'd0, v); chk("fa_r0", v, W'(8));
        chk("fa_err", W'(err), W'(0));

        // Host write on the handshake edge feeds the operand: r5 = 100 + 3
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = W'(100);
        send(4'b0000, 0, 0, 0, 3'd5, 3'd4, 3'd1);
        wr_en = 1'b0;
        watch(0, 40, en_cyc, en_cnt, done_cyc, end_cyc);
        rdreg(3'd5, v); chk("fwd_r5", v, W'(103));
        rdreg(3'd4, v); chk("fwd_r4", v, W'(100));

        // Swap exchanges r1/r2
        wr(3'd1, W'(5));
        wr(3'd2, W'(9));
        send(4'b0000, 1, 1, 0, 3'd0, 3'd1, 3'd2);
        watch(0, 40, en_cyc, en_cnt, done_cyc, end_cyc);
        chk("swap_done_cyc", W'(done_cyc), W'(7));
        rdreg(3'd1, v); chk("swap_r1", v, W'(9));
        rdreg(3'd2, v); chk("swap_r2", v, W'(5));
        rdreg(3'd0, v); chk("swap_r0", v, W'(8));

        // Swap with srca == srcb writes only alu_r
        wr(3'd3, W'(7));
        stub_xor = W'(8'hFF);
        send(4'b0000, 1, 1, 0, 3'd0, 3'd3, 3'd3);
        watch(0, 40, en_cyc, en_cnt, done_cyc, end_cyc);
        stub_xor = '0;
        rdreg(3'd3, v); chk("swap_same_r3", v, W'(7));

        // Illegal opcode: no issue, err, done next cycle
        send(4'b0011, 0, 0, 0, 3'd0, 3'd1, 3'd2);
        watch(0, 40, en_cyc, en_cnt, done_cyc, end_cyc);
        chk("ill_en_cnt", W'(en_cnt), W'(0));
        chk("ill_done_cyc", W'(done_cyc), W'(1));
        chk("ill_err", W'(err), W'(1));
        rdreg(3'd0, v); chk("ill_r0", v, W'(8));
        rdreg(3'd1, v); chk("ill_r1", v, W'(9));
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("ill_err_clr", W'(err), W'(0));

        // Set beats simultaneous clear
        err_clr = 1'b1;
        send(4'b0111, 0, 0, 0, 3'd0, 3'd1, 3'd2);
        err_clr = 1'b0;
        chk("set_wins", W'(err), W'(1));
        tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("clr_after", W'(err), W'(0));

        // ALU busy for 10 cycles at issue: r5 = 9 + 5
        alu_status = 2'b01;
        send(op_mul_n, 0, 0, 0, 3'd5, 3'd1, 3'd2);
        watch(10, 60, en_cyc, en_cnt, done_cyc, end_cyc);
        chk("stall_en_cyc", W'(en_cyc), W'(11));
        chk("stall_en_cnt", W'(en_cnt), W'(1));
        chk("stall_done_cyc", W'(done_cyc), W'(17));
        chk("stall_opcode", W'(stub_op), W'(4'b1001));
        rdreg(3'd5, v); chk("stall_r5", v, W'(14));

        // Reset while waiting: outputs clear at once; late vld is ignored
        send(4'b0000, 0, 0, 0, 3'd6, 3'd1, 3'd1);
        tick(); tick(); tick();
        chk("mid_busy_pre", W'(busy), W'(1));
        rst = 1'b0;
        #1;
        chk("mid_busy", W'(busy), W'(0));
        chk("mid_alu_a", alu_a, W'(0));
        chk("mid_alu_en", W'(alu_en), W'(0));
        chk("mid_done", W'(done), W'(0));
        tick();
        rst = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_seen = 1;
            tick();
        end
        chk("mid_no_done", W'(done_seen), W'(0));
        rdreg(3'd6, v); chk("mid_r6", v, W'(0));
        wr(3'd1, W'(2));
        wr(3'd2, W'(3));
        send(4'b0000, 0, 0, 0, 3'd7, 3'd1, 3'd2);
        watch(0, 40, en_cyc, en_cnt, done_cyc, end_cyc);
        chk("post_done_cyc", W'(done_cyc), W'(7));
        rdreg(3'd7, v); chk("post_r7", v, W'(5));

        // ALU never answers: abort after the full wait budget
        stub_hang = 1;
        send(4'b0000, 0, 0, 1, 3'd7, 3'd1, 3'd2);
        watch(0, 70000, en_cyc, en_cnt, done_cyc, end_cyc);
        stub_hang = 0;
        chk("tmo_end_cyc", W'(end_cyc), W'(65537));
        chk("tmo_no_done", W'(done_cyc), W'(-1));
        chk("tmo_err", W'(err), W'(1));
        chk("tmo_ready", W'(cmd_ready), W'(1));
        rdreg(3'd7, v); chk("tmo_r7", v, W'(5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
